// File: rtl/asym_ram_pkg.sv
// asym_ram_pkg: lane geometry, legal widths/capacities and address-width helpers for the asymmetric RAM.
package asym_ram_pkg;
    localparam int LANE_WIDTH   = 9;
    localparam int WIDTH_9      = 9;
    localparam int WIDTH_18     = 18;
    localparam int WIDTH_36     = 36;
    localparam int MEM_BITS_18K = 18432;
    localparam int MEM_BITS_36K = 36864;

    function automatic bit legal_width(input int w);
        return w == WIDTH_9 || w == WIDTH_18 || w == WIDTH_36;
    endfunction

    function automatic bit legal_capacity(input int m);
        return m == MEM_BITS_18K || m == MEM_BITS_36K;
    endfunction

    function automatic int lane_ratio(input int w);
        return w / LANE_WIDTH;
    endfunction

    function automatic int addr_width(input int mem_bits, input int w);
        return $clog2(mem_bits / w);
    endfunction
endpackage

// File: rtl/asym_ram_lane_array.sv
// asym_ram_lane_array: 9-bit-lane storage, one lane-enabled write port and one asynchronous read port.
module asym_ram_lane_array
    import asym_ram_pkg::*;
#(
    parameter int LANES    = 2048,
    parameter int WR_LANES = 1,
    parameter int RD_LANES = 4,
    localparam int LW      = $clog2(LANES)
) (
    input  logic                           clk_i,
    input  logic [WR_LANES-1:0]            we_i,
    input  logic [LW-1:0]                  wlane_i,
    input  logic [WR_LANES*LANE_WIDTH-1:0] wdata_i,
    input  logic [LW-1:0]                  rlane_i,
    output logic [RD_LANES*LANE_WIDTH-1:0] rdata_o
);
    logic [LANE_WIDTH-1:0] mem_q [LANES];

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < WR_LANES; k++)
            if (we_i[k]) mem_q[wlane_i + LW'(k)] <= wdata_i[k*LANE_WIDTH +: LANE_WIDTH];
    end

    for (genvar j = 0; j < RD_LANES; j++) begin : g_rd
        assign rdata_o[j*LANE_WIDTH +: LANE_WIDTH] = mem_q[rlane_i + LW'(j)];
    end
endmodule

// File: rtl/asym_sdp_ram.sv
// asym_sdp_ram: single-clock asymmetric simple-dual-port RAM, read-first, 9-bit lanes.
// Define ASYM_SDP_RAM_OUT_REG_EN to add an output register stage (read latency 2).
module asym_sdp_ram
    import asym_ram_pkg::*;
#(
    parameter int WR_DATA_WIDTH  = 9,
    parameter int RD_DATA_WIDTH  = 36,
    parameter int MEM_BITS       = 18432,
    localparam int BE_WIDTH      = lane_ratio(WR_DATA_WIDTH),
    localparam int WR_ADDR_WIDTH = addr_width(MEM_BITS, WR_DATA_WIDTH),
    localparam int RD_ADDR_WIDTH = addr_width(MEM_BITS, RD_DATA_WIDTH)
) (
    input  logic                     CLK_i,
    input  logic                     RESET_i,
    input  logic                     WEN_i,
    input  logic [BE_WIDTH-1:0]      WR_BE_i,
    input  logic [WR_ADDR_WIDTH-1:0] WR_ADDR_i,
    input  logic [WR_DATA_WIDTH-1:0] WDATA_i,
    input  logic                     REN_i,
    input  logic [RD_ADDR_WIDTH-1:0] RD_ADDR_i,
    output logic [RD_DATA_WIDTH-1:0] RDATA_o,
    output logic                     RVALID_o
);
    localparam int LANES    = MEM_BITS / LANE_WIDTH;
    localparam int RD_LANES = lane_ratio(RD_DATA_WIDTH);
    localparam int LW       = $clog2(LANES);

    if (!legal_width(WR_DATA_WIDTH) || !legal_width(RD_DATA_WIDTH) || !legal_capacity(MEM_BITS)) begin : g_bad_cfg
        $error("asym_sdp_ram: illegal WR_DATA_WIDTH/RD_DATA_WIDTH/MEM_BITS");
    end

    logic [BE_WIDTH-1:0]      lane_we;
    logic [LW-1:0]            wr_lane, rd_lane;
    logic [RD_DATA_WIDTH-1:0] mem_rdata, rdata_q, rdata_d;
    logic                     rvalid_q, rvalid_d;

    // A write seen while reset is high is dropped; storage itself is never cleared.
    always_comb begin
        lane_we  = (WEN_i && !RESET_i) ? WR_BE_i : '0;
        wr_lane  = LW'(int'(WR_ADDR_i) * BE_WIDTH);
        rd_lane  = LW'(int'(RD_ADDR_i) * RD_LANES);
        rdata_d  = REN_i ? mem_rdata : rdata_q;
        rvalid_d = REN_i;
    end

    asym_ram_lane_array #(
        .LANES    (LANES),
        .WR_LANES (BE_WIDTH),
        .RD_LANES (RD_LANES)
    ) u_array (
        .clk_i   (CLK_i),
        .we_i    (lane_we),
        .wlane_i (wr_lane),
        .wdata_i (WDATA_i),
        .rlane_i (rd_lane),
        .rdata_o (mem_rdata)
    );

    // Sampling the pre-edge array output gives read-first collision behaviour.
    always_ff @(posedge CLK_i or posedge RESET_i) begin
        if (RESET_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef ASYM_SDP_RAM_OUT_REG_EN
    logic [RD_DATA_WIDTH-1:0] out_q, out_d;
    logic                     out_vld_q, out_vld_d;

    always_comb begin
        out_d     = rvalid_q ? rdata_q : out_q;
        out_vld_d = rvalid_q;
    end

    always_ff @(posedge CLK_i or posedge RESET_i) begin
        if (RESET_i) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign RDATA_o  = out_q;
    assign RVALID_o = out_vld_q;
`else
    assign RDATA_o  = rdata_q;
    assign RVALID_o = rvalid_q;
`endif
endmodule

// File: tb/tb_asym_sdp_ram.sv
// tb_asym_sdp_ram: directed scoreboard bench over four width/capacity configurations of asym_sdp_ram.
`timescale 1ns/1ps
module tb_asym_sdp_ram;
`ifdef ASYM_SDP_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    typedef struct {
        int          inst;
        logic [35:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wen = '0;
    logic [3:0]  ren = '0;
    logic [3:0]  be = '0;
    logic [10:0] waddr = '0;
    logic [10:0] raddr = '0;
    logic [35:0] wdata = '0;
    logic [35:0] rd_a, rd_d;
    logic [8:0]  rd_b;
    logic [17:0] rd_c;
    logic [3:0]  rv;
    exp_t        sb[$];
    int          tests = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    asym_sdp_ram #(.WR_DATA_WIDTH(9), .RD_DATA_WIDTH(36), .MEM_BITS(18432)) u_a (
        .CLK_i(clk), .RESET_i(rst), .WEN_i(wen[0]), .WR_BE_i(be[0:0]), .WR_ADDR_i(waddr),
        .WDATA_i(wdata[8:0]), .REN_i(ren[0]), .RD_ADDR_i(raddr[8:0]), .RDATA_o(rd_a), .RVALID_o(rv[0]));
    asym_sdp_ram #(.WR_DATA_WIDTH(36), .RD_DATA_WIDTH(9), .MEM_BITS(18432)) u_b (
        .CLK_i(clk), .RESET_i(rst), .WEN_i(wen[1]), .WR_BE_i(be), .WR_ADDR_i(waddr[8:0]),
        .WDATA_i(wdata), .REN_i(ren[1]), .RD_ADDR_i(raddr), .RDATA_o(rd_b), .RVALID_o(rv[1]));
    asym_sdp_ram #(.WR_DATA_WIDTH(18), .RD_DATA_WIDTH(18), .MEM_BITS(18432)) u_c (
        .CLK_i(clk), .RESET_i(rst), .WEN_i(wen[2]), .WR_BE_i(be[1:0]), .WR_ADDR_i(waddr[9:0]),
        .WDATA_i(wdata[17:0]), .REN_i(ren[2]), .RD_ADDR_i(raddr[9:0]), .RDATA_o(rd_c), .RVALID_o(rv[2]));
    asym_sdp_ram #(.WR_DATA_WIDTH(36), .RD_DATA_WIDTH(36), .MEM_BITS(36864)) u_d (
        .CLK_i(clk), .RESET_i(rst), .WEN_i(wen[3]), .WR_BE_i(be), .WR_ADDR_i(waddr[9:0]),
        .WDATA_i(wdata), .REN_i(ren[3]), .RD_ADDR_i(raddr[9:0]), .RDATA_o(rd_d), .RVALID_o(rv[3]));

    function automatic logic [35:0] rdata_of(input int i);
        return i == 0 ? rd_a : i == 1 ? 36'(rd_b) : i == 2 ? 36'(rd_c) : rd_d;
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdata_a"}, rd_a, '0);
        chk({tag, "_rdata_b"}, 36'(rd_b), '0);
        chk({tag, "_rdata_c"}, 36'(rd_c), '0);
        chk({tag, "_rdata_d"}, rd_d, '0);
        chk({tag, "_rvalid"}, 36'(rv), '0);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (rv[i] !== 1'b0) begin
                    if (sb.size() == 0) begin
                        tests++;
                        failed++;
                        $error("FAIL spurious_rvalid%0d: observed rvalid %b expected no read pending", i, rv[i]);
                    end else begin
                        exp_t e = sb.pop_front();
                        chk($sformatf("read_inst%0d", i), 36'(i), 36'(e.inst));
                        chk($sformatf("read_data%0d", i), rdata_of(i), e.data);
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        wen = '0;
        ren = '0;
    endtask

    task automatic wr(input int i, input int a, input logic [35:0] d, input logic [3:0] b);
        wen[i] = 1'b1;
        waddr  = 11'(a);
        wdata  = d;
        be     = b;
        cyc();
    endtask

    task automatic rd(input int i, input int a, input logic [35:0] e);
        ren[i] = 1'b1;
        raddr  = 11'(a);
        sb.push_back('{i, e});
        cyc();
    endtask

    initial begin
        logic [35:0] word36;
        logic [35:0] word_a1;
        word36  = 36'h1_2345_6789;
        word_a1 = {9'h100, 9'h0AB, 9'h1C3, 9'h011};
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        wr(0, 0, 36'h1AA, 4'h1);
        wr(0, 1, 36'h055, 4'h1);
        wr(0, 2, 36'h123, 4'h1);
        wr(0, 3, 36'h0FF, 4'h1);
        wr(0, 4, 36'h011, 4'h1);
        wr(0, 5, 36'h1C3, 4'h1);
        wr(0, 6, 36'h0AB, 4'h1);
        wr(0, 7, 36'h100, 4'h1);
        rd(0, 0, {9'h0FF, 9'h123, 9'h055, 9'h1AA});
        rd(0, 1, word_a1);
        repeat (LAT) cyc();
        for (int n = 0; n < 5; n++) begin
            chk("hold_rdata", rd_a, word_a1);
            chk("hold_rvalid", 36'(rv[0]), '0);
            cyc();
        end

        wr(1, 7, word36, 4'hF);
        for (int j = 0; j < 4; j++) rd(1, 28 + j, (word36 >> (9 * j)) & 36'h1FF);

        wr(2, 3, 36'h3FFFF, 4'b0011);
        wr(2, 3, 36'h00000, 4'b0010);
        rd(2, 3, 36'h001FF);
        wr(2, 3, 36'h2AAAA, 4'b0000);
        rd(2, 3, 36'h001FF);
        wr(2, 1023, 36'h15A5A, 4'b0011);
        rd(2, 1023, 36'h15A5A);

        wr(3, 2, 36'hA_5A5A_5A5A, 4'hF);
        wen[3] = 1'b1;
        waddr  = 11'd2;
        wdata  = '0;
        be     = 4'hF;
        ren[3] = 1'b1;
        raddr  = 11'd2;
        sb.push_back('{3, 36'hA_5A5A_5A5A});
        cyc();
        rd(3, 2, 36'h0);

        wr(3, 5, 36'h9_8765_4321, 4'hF);
        wr(3, 6, 36'h1_1111_1111, 4'hF);
        ren[3] = 1'b1;
        raddr  = 11'd5;
        sb.push_back('{3, 36'h9_8765_4321});
        @(negedge clk);
        sb.push_back('{3, 36'h9_8765_4321});
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_idle("async_reset");
        sb.delete();
        ren    = '0;
        wen[3] = 1'b1;
        waddr  = 11'd6;
        wdata  = '0;
        be     = 4'hF;
        @(posedge clk);
        @(negedge clk);
        wen = '0;
        rst = 1'b0;
        chk_idle("reset_release");
        rd(3, 6, 36'h1_1111_1111);
        rd(3, 5, 36'h9_8765_4321);
        rd(0, 0, {9'h0FF, 9'h123, 9'h055, 9'h1AA});
        rd(2, 3, 36'h001FF);

        repeat (LAT + 1) cyc();
        chk("scoreboard_drained", 36'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/asym_sdp_ram.md
# asym_sdp_ram

Parametrised single-clock asymmetric simple-dual-port block-RAM model with independent write and read widths in 9-bit lanes, per-lane write enables, read-first collision semantics and a read-valid flag. It supersedes the fixed 9/18-bit two-clock wrappers as the generic target for inferred and instantiated BRAM18K/BRAM36K mapping tests. It also serves as the golden model in the qlf_k6n10f BRAM test flows.

## Interface
- WR_DATA_WIDTH, 9: write port width; one of 9, 18, 36.
- RD_DATA_WIDTH, 36: read port width; one of 9, 18, 36.
- MEM_BITS, 18432: total capacity; 18432 or 36864.
- Derived, not overridable: BE_WIDTH = WR_DATA_WIDTH/9; WR_ADDR_WIDTH = clog2(MEM_BITS/WR_DATA_WIDTH); RD_ADDR_WIDTH = clog2(MEM_BITS/RD_DATA_WIDTH).
- CLK_i  in  1  sole clock; all state updates on the rising edge.
- RESET_i  in  1  asynchronous, active-high reset.
- WEN_i  in  1  write enable.
- WR_BE_i  in  BE_WIDTH  per-9-bit-lane write enable; bit k covers WDATA_i[9k+8:9k].
- WR_ADDR_i  in  WR_ADDR_WIDTH  write word address.
- WDATA_i  in  WR_DATA_WIDTH  write data.
- REN_i  in  1  read enable.
- RD_ADDR_i  in  RD_ADDR_WIDTH  read word address.
- RDATA_o  out  RD_DATA_WIDTH  read data; holds its value between reads.
- RVALID_o  out  1  one-cycle pulse marking new RDATA_o.

## Operation
- Storage is MEM_BITS/9 lanes of 9 bits. Lane index of write lane k is WR_ADDR_i*BE_WIDTH+k. Lane index of read lane j is RD_ADDR_i*(RD_DATA_WIDTH/9)+j.
- Mapping is little-endian: the lowest address occupies the lowest bits of a wider word. Example: a 9-bit write to address 5 lands in RDATA_o[17:9] of 36-bit word 1.
- Write: when WEN_i=1, each lane with WR_BE_i[k]=1 is updated. Lanes with WR_BE_i[k]=0 keep their content. WEN_i=1 with WR_BE_i=0 changes nothing.
- Read: when REN_i=1, the addressed lanes are captured into the read register. When REN_i=0, RDATA_o holds and RVALID_o=0.
- Collision (same cycle, overlapping lanes): read-first. The read returns pre-write content for those lanes. Non-overlapping lanes return current content.
- Memory array is not reset. Its content is undefined until written.
- Out-of-range addresses are not possible: the address widths exactly cover MEM_BITS.
- Parameter check: an illegal width or capacity triggers an elaboration-time $error.

## Timing
- Reset values: RDATA_o=0, RVALID_o=0, output pipeline register=0. Asserting RESET_i mid-stream clears them immediately and drops any in-flight read.
- Memory content survives reset. A write presented in the same cycle RESET_i is asserted is discarded.
- Read latency without macro: 1 cycle. REN_i sampled at edge n gives RDATA_o/RVALID_o valid after edge n.
- Read latency with macro: 2 cycles (see Configuration).
- Write-to-read visibility: a write at edge n is readable by a read sampled at edge n+1.
- Back-to-back reads at full rate are supported. RVALID_o stays high on consecutive cycles.

## Configuration
- ASYM_SDP_RAM_OUT_REG_EN defined: an extra output register stage is inserted after the read register. Read latency is 2 and RVALID_o is delayed to match. The second stage loads only when the first stage holds valid data, so RDATA_o still holds between reads.
- Macro undefined: single read register, latency 1.
- Collision semantics and reset values are identical in both builds.

## Structure
- Package asym_ram_pkg holds:
  - LANE_WIDTH=9.
  - Legal width and capacity constants.
  - Functions for lane ratio and address widths.
- Sub-module asym_ram_lane_array: 9-bit-lane storage with one write port (lane-enable vector) and one read port.
- The top level owns address-to-lane translation, the read register, the optional output stage and the RVALID_o generation.

## Test plan
- Width conversion, 9 in / 36 out: write 0x1AA, 0x055, 0x123, 0x0FF to addresses 0-3, then read address 0 -> RDATA_o={0x0FF,0x123,0x055,0x1AA} one cycle later (two with macro), with a one-cycle RVALID_o pulse.
- Width conversion, 36 in / 9 out: write 0x1_2345_6789 to address 7 with BE=4'b1111, then read addresses 28-31 -> lanes returned low-first, matching the 9-bit slices.
- Partial write: 18 in / 18 out; write 0x3FFFF then 0x00000 with BE=2'b10 to address 3 -> read returns 0x001FF.
- Collision: 36/36; address 2 holds 0xA5A5A5A5A; write 0x0 to address 2 with REN_i=1 on the same address -> read returns 0xA5A5A5A5A; the next read returns 0x0.
- Reset: assert RESET_i during a read burst -> RDATA_o=0 and RVALID_o=0 asynchronously; memory content is unchanged on reads after release.
- Hold: REN_i=0 for 5 cycles after a read -> RDATA_o is stable and RVALID_o=0 throughout.
